// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-to-one memory port arbiter.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        IBUSY = 2'd1,
        DBUSY = 2'd2
    } arb_state_t;

    localparam logic       MEM_RD    = 1'b0;
    localparam logic       MEM_WR    = 1'b1;
    localparam logic [3:0] MASK_WORD = 4'hF;

endpackage

// File: rtl/mem_arbiter_if.sv
// Bundle of fetch, load/store and shared-memory signals around the arbiter.
//
// Handshake: a requester raises *_request and holds it (with stable
// address/data) until its *_valid pulses for one cycle; *_err qualifies that
// pulse. The arbiter holds mem_request and all mem_* fields stable until the
// memory returns a one-cycle mem_valid (with mem_rdata) or the arbiter gives up.
interface mem_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              i_request;
    logic [ADDR_W-1:0] i_addr;
    logic              i_valid;
    logic [DATA_W-1:0] i_rdata;
    logic              i_err;

    logic              d_request;
    logic              d_we_re;
    logic [3:0]        d_mask;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic              d_valid;
    logic [DATA_W-1:0] d_rdata;
    logic              d_err;

    logic              mem_request;
    logic              mem_we_re;
    logic [3:0]        mem_mask;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_valid;
    logic [DATA_W-1:0] mem_rdata;

    // Arbiter side
    modport slave (
        input  i_request, i_addr,
        output i_valid, i_rdata, i_err,
        input  d_request, d_we_re, d_mask, d_addr, d_wdata,
        output d_valid, d_rdata, d_err,
        output mem_request, mem_we_re, mem_mask, mem_addr, mem_wdata,
        input  mem_valid, mem_rdata
    );

    // Core and memory side
    modport master (
        output i_request, i_addr,
        input  i_valid, i_rdata, i_err,
        output d_request, d_we_re, d_mask, d_addr, d_wdata,
        input  d_valid, d_rdata, d_err,
        input  mem_request, mem_we_re, mem_mask, mem_addr, mem_wdata,
        output mem_valid, mem_rdata
    );
endinterface

// File: rtl/mem_arb_timer.sv
// Busy-cycle counter: cleared on grant, counts while busy, flags the last
// allowed cycle so the arbiter can abort a transaction the memory never ends.
module mem_arb_timer #(
    parameter int TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic count,
    output logic expire
);
    localparam int TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    logic [TW-1:0] cnt;

    // Last busy cycle before abort is when the count reaches TIMEOUT-1
    assign expire = count && (cnt == TW'(TIMEOUT - 1));

    // Clear on grant, advance once per busy cycle, hold at the expiry value
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= '0;
        end else if (count && !expire) begin
            cnt <= cnt + TW'(1);
        end
    end
endmodule

// File: rtl/mem_arbiter.sv
// Two-to-one arbiter between the core's fetch and load/store ports and one
// shared memory port, with a fetch starvation guard and a response timeout.
import mem_arb_pkg::*;

module mem_arbiter #(
    parameter int ADDR_W          = 32,
    parameter int DATA_W          = 32,
    parameter int MAX_DATA_STREAK = 4,
    parameter int TIMEOUT         = 16
) (
    input  logic       clk,
    input  logic       rst,
    mem_arbiter_if.slave bus,
    output arb_state_t dbg_state
);
    localparam int SW = $clog2(MAX_DATA_STREAK + 1);

    arb_state_t        state;
    logic [SW-1:0]     streak;
    logic              req_q;
    logic              we_q;
    logic [3:0]        mask_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic              expire;
    logic              streak_full;
    logic              grant;

    assign streak_full = (streak == SW'(MAX_DATA_STREAK));
    assign grant       = (state == IDLE) && (bus.i_request || bus.d_request);
    assign dbg_state   = state;

    assign bus.mem_request = req_q;
    assign bus.mem_we_re   = we_q;
    assign bus.mem_mask    = mask_q;
    assign bus.mem_addr    = addr_q;
    assign bus.mem_wdata   = wdata_q;

    mem_arb_timer #(.TIMEOUT(TIMEOUT)) u_timer (
        .clk    (clk),
        .rst    (rst),
        .load   (grant),
        .count  (state != IDLE),
        .expire (expire)
    );

    // Arbitration FSM: picks a winner in IDLE, latches its transaction and
    // holds it until completion or timeout; data wins unless fetch has waited
    // through MAX_DATA_STREAK data grants in a row.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            streak  <= '0;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            mask_q  <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.d_request && !(bus.i_request && streak_full)) begin
                        state   <= DBUSY;
                        req_q   <= 1'b1;
                        we_q    <= bus.d_we_re ? MEM_WR : MEM_RD;
                        mask_q  <= bus.d_mask;
                        addr_q  <= bus.d_addr;
                        wdata_q <= bus.d_wdata;
                        if (!bus.i_request) begin
                            streak <= '0;
                        end else if (!streak_full) begin
                            streak <= streak + SW'(1);
                        end
                    end else if (bus.i_request) begin
                        state   <= IBUSY;
                        req_q   <= 1'b1;
                        we_q    <= MEM_RD;
                        mask_q  <= MASK_WORD;
                        addr_q  <= bus.i_addr;
                        wdata_q <= '0;
                        streak  <= '0;
                    end
                end
                IBUSY, DBUSY: begin
                    if (bus.mem_valid || expire) begin
                        state <= IDLE;
                        req_q <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    req_q <= 1'b0;
                end
            endcase
        end
    end

    // Route completion or abort to the owner only; a real response wins over
    // expiry in the same cycle, and responses in IDLE are dropped.
    always_comb begin
        bus.i_valid = 1'b0;
        bus.i_err   = 1'b0;
        bus.i_rdata = '0;
        bus.d_valid = 1'b0;
        bus.d_err   = 1'b0;
        bus.d_rdata = '0;
        if (state == IBUSY) begin
            bus.i_valid = bus.mem_valid || expire;
            bus.i_err   = expire && !bus.mem_valid;
            bus.i_rdata = bus.mem_valid ? bus.mem_rdata : '0;
        end else if (state == DBUSY) begin
            bus.d_valid = bus.mem_valid || expire;
            bus.d_err   = expire && !bus.mem_valid;
            bus.d_rdata = bus.mem_valid ? bus.mem_rdata : '0;
        end
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: per-scenario tasks with inline checks,
// plus a negedge monitor that pops expected grants and responses from queues.
module tb_mem_arbiter;
    import mem_arb_pkg::*;

    logic       clk;
    logic       rst;
    arb_state_t dbg_state;

    int compared   = 0;
    int mismatched = 0;

    logic [31:0] exp_grant_q[$];
    logic [32:0] exp_i_q[$];
    logic [32:0] exp_d_q[$];

    mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    mem_arbiter #(
        .ADDR_W(32), .DATA_W(32), .MAX_DATA_STREAK(4), .TIMEOUT(16)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .dbg_state (dbg_state)
    );

    // Clock and global watchdog
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, want finished", $time);
        $fatal(1, "watchdog expired");
    end

    // Monitor: grant order by latched address, and owner responses
    logic        prev_req;
    logic [31:0] g_exp;
    logic [32:0] r_exp;
    always @(negedge clk) begin
        if (!rst) begin
            prev_req = 1'b0;
        end else begin
            if (bus.mem_request && !prev_req) begin
                compared++;
                if (exp_grant_q.size() == 0) begin
                    mismatched++;
                    $display("FAIL grant_order: got grant addr=%h, want no grant", bus.mem_addr);
                end else begin
                    g_exp = exp_grant_q.pop_front();
                    if (bus.mem_addr !== g_exp) begin
                        mismatched++;
                        $display("FAIL grant_order: got addr=%h, want %h", bus.mem_addr, g_exp);
                    end
                end
            end
            prev_req = bus.mem_request;
            if (bus.i_valid) begin
                compared++;
                if (exp_i_q.size() == 0) begin
                    mismatched++;
                    $display("FAIL i_resp: got i_valid err=%b rdata=%h, want none", bus.i_err, bus.i_rdata);
                end else begin
                    r_exp = exp_i_q.pop_front();
                    if ({bus.i_err, bus.i_rdata} !== r_exp) begin
                        mismatched++;
                        $display("FAIL i_resp: got err=%b rdata=%h, want err=%b rdata=%h",
                                 bus.i_err, bus.i_rdata, r_exp[32], r_exp[31:0]);
                    end
                end
            end
            if (bus.d_valid) begin
                compared++;
                if (exp_d_q.size() == 0) begin
                    mismatched++;
                    $display("FAIL d_resp: got d_valid err=%b rdata=%h, want none", bus.d_err, bus.d_rdata);
                end else begin
                    r_exp = exp_d_q.pop_front();
                    if ({bus.d_err, bus.d_rdata} !== r_exp) begin
                        mismatched++;
                        $display("FAIL d_resp: got err=%b rdata=%h, want err=%b rdata=%h",
                                 bus.d_err, bus.d_rdata, r_exp[32], r_exp[31:0]);
                    end
                end
            end
        end
    end

    // Driver helpers
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_req(output bit ok);
        ok = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (bus.mem_request) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        compared++;
        if ({bus.mem_request, bus.mem_we_re, bus.mem_mask, bus.mem_addr, bus.mem_wdata} !== '0) begin
            mismatched++;
            $display("FAIL reset_mem: got req=%b we=%b mask=%h addr=%h wdata=%h, want all 0",
                     bus.mem_request, bus.mem_we_re, bus.mem_mask, bus.mem_addr, bus.mem_wdata);
        end
        compared++;
        if ({bus.i_valid, bus.i_err, bus.i_rdata, bus.d_valid, bus.d_err, bus.d_rdata} !== '0 ||
            dbg_state !== IDLE) begin
            mismatched++;
            $display("FAIL reset_resp: got i_valid=%b d_valid=%b state=%0d, want 0/0/IDLE",
                     bus.i_valid, bus.d_valid, dbg_state);
        end
        tick();
        rst = 1'b1;
        tick();
    endtask

    task automatic test_fetch();
        bit ok;
        bus.i_addr    = 32'h100;
        bus.i_request = 1'b1;
        exp_grant_q.push_back(32'h100);
        exp_i_q.push_back({1'b0, 32'h0050_0093});
        wait_req(ok);
        compared++;
        if (!ok) begin mismatched++; $display("FAIL fetch_req: got mem_request=0, want 1"); end
        compared++;
        if ({bus.mem_we_re, bus.mem_mask, bus.mem_addr, bus.mem_wdata} !== {1'b0, 4'hF, 32'h100, 32'h0}) begin
            mismatched++;
            $display("FAIL fetch_fields: got we=%b mask=%h addr=%h wdata=%h, want 0/f/100/0",
                     bus.mem_we_re, bus.mem_mask, bus.mem_addr, bus.mem_wdata);
        end
        repeat (3) tick();
        bus.mem_valid = 1'b1;
        bus.mem_rdata = 32'h0050_0093;
        @(negedge clk);
        compared++;
        if ({bus.i_valid, bus.d_valid, bus.d_rdata} !== {1'b1, 1'b0, 32'h0}) begin
            mismatched++;
            $display("FAIL fetch_done: got i_valid=%b d_valid=%b d_rdata=%h, want 1/0/0",
                     bus.i_valid, bus.d_valid, bus.d_rdata);
        end
        tick();
        bus.mem_valid = 1'b0;
        bus.i_request = 1'b0;
        @(negedge clk);
        compared++;
        if ({bus.mem_request, bus.i_valid} !== 2'b00) begin
            mismatched++;
            $display("FAIL fetch_after: got mem_request=%b i_valid=%b, want 0/0", bus.mem_request, bus.i_valid);
        end
        tick();
    endtask

    task automatic test_store();
        bit ok;
        bus.d_we_re    = 1'b1;
        bus.d_mask     = 4'b0011;
        bus.d_addr     = 32'h2004;
        bus.d_wdata    = 32'hBEEF;
        bus.d_request  = 1'b1;
        exp_grant_q.push_back(32'h2004);
        exp_d_q.push_back({1'b0, 32'h5A5A});
        wait_req(ok);
        compared++;
        if (!ok) begin mismatched++; $display("FAIL store_req: got mem_request=0, want 1"); end
        for (int k = 0; k < 3; k++) begin
            compared++;
            if ({bus.mem_request, bus.mem_we_re, bus.mem_mask, bus.mem_addr, bus.mem_wdata} !==
                {1'b1, 1'b1, 4'b0011, 32'h2004, 32'hBEEF}) begin
                mismatched++;
                $display("FAIL store_stable[%0d]: got req=%b we=%b mask=%h addr=%h wdata=%h, want 1/1/3/2004/beef",
                         k, bus.mem_request, bus.mem_we_re, bus.mem_mask, bus.mem_addr, bus.mem_wdata);
            end
            if (k == 0) begin
                bus.d_addr  = 32'h9999;
                bus.d_wdata = 32'h1234;
            end
            @(negedge clk);
        end
        tick();
        bus.mem_valid = 1'b1;
        bus.mem_rdata = 32'h5A5A;
        @(negedge clk);
        compared++;
        if ({bus.d_valid, bus.d_err, bus.i_valid} !== 3'b100) begin
            mismatched++;
            $display("FAIL store_done: got d_valid=%b d_err=%b i_valid=%b, want 1/0/0",
                     bus.d_valid, bus.d_err, bus.i_valid);
        end
        tick();
        bus.mem_valid = 1'b0;
        bus.d_request = 1'b0;
        bus.d_we_re   = 1'b0;
        tick();
    endtask

    task automatic test_contention();
        bit ok;
        bus.i_addr    = 32'h300;
        bus.d_addr    = 32'h400;
        bus.d_we_re   = 1'b0;
        bus.d_mask    = 4'hF;
        for (int t = 0; t < 10; t++) begin
            if (t == 4 || t == 9) begin
                exp_grant_q.push_back(32'h300);
                exp_i_q.push_back({1'b0, 32'hA000_0000 + 32'(t)});
            end else begin
                exp_grant_q.push_back(32'h400);
                exp_d_q.push_back({1'b0, 32'hA000_0000 + 32'(t)});
            end
        end
        bus.i_request = 1'b1;
        bus.d_request = 1'b1;
        for (int t = 0; t < 10; t++) begin
            wait_req(ok);
            compared++;
            if (!ok) begin mismatched++; $display("FAIL contention_req[%0d]: got mem_request=0, want 1", t); end
            tick();
            bus.mem_valid = 1'b1;
            bus.mem_rdata = 32'hA000_0000 + 32'(t);
            tick();
            bus.mem_valid = 1'b0;
        end
        bus.i_request = 1'b0;
        bus.d_request = 1'b0;
        repeat (2) tick();
    endtask

    task automatic test_timeout();
        bit ok;
        bus.d_addr    = 32'h500;
        bus.d_request = 1'b1;
        exp_grant_q.push_back(32'h500);
        exp_d_q.push_back({1'b1, 32'h0});
        wait_req(ok);
        compared++;
        if (!ok) begin mismatched++; $display("FAIL timeout_req: got mem_request=0, want 1"); end
        for (int k = 1; k <= 16; k++) begin
            if (k > 1) @(negedge clk);
            compared++;
            if (bus.d_valid !== (k == 16)) begin
                mismatched++;
                $display("FAIL timeout_cycle[%0d]: got d_valid=%b, want %b", k, bus.d_valid, (k == 16));
            end
        end
        compared++;
        if (bus.d_err !== 1'b1) begin
            mismatched++;
            $display("FAIL timeout_err: got d_err=%b, want 1", bus.d_err);
        end
        tick();
        bus.d_request = 1'b0;
        bus.mem_valid = 1'b1;
        bus.mem_rdata = 32'hDEAD_BEEF;
        @(negedge clk);
        compared++;
        if ({bus.d_valid, bus.i_valid, bus.mem_request} !== 3'b000) begin
            mismatched++;
            $display("FAIL late_resp: got d_valid=%b i_valid=%b mem_request=%b, want 0/0/0",
                     bus.d_valid, bus.i_valid, bus.mem_request);
        end
        tick();
        bus.mem_valid = 1'b0;
        tick();
    endtask

    task automatic test_timeout_boundary();
        bit ok;
        bus.d_addr    = 32'h600;
        bus.d_request = 1'b1;
        exp_grant_q.push_back(32'h600);
        exp_d_q.push_back({1'b0, 32'hCAFE_F00D});
        wait_req(ok);
        compared++;
        if (!ok) begin mismatched++; $display("FAIL boundary_req: got mem_request=0, want 1"); end
        repeat (15) tick();
        bus.mem_valid = 1'b1;
        bus.mem_rdata = 32'hCAFE_F00D;
        @(negedge clk);
        compared++;
        if ({bus.d_valid, bus.d_err, bus.d_rdata} !== {1'b1, 1'b0, 32'hCAFE_F00D}) begin
            mismatched++;
            $display("FAIL boundary_done: got d_valid=%b d_err=%b d_rdata=%h, want 1/0/cafef00d",
                     bus.d_valid, bus.d_err, bus.d_rdata);
        end
        tick();
        bus.mem_valid = 1'b0;
        bus.d_request = 1'b0;
        tick();
    endtask

    task automatic test_reset_mid();
        bit ok;
        bus.i_addr    = 32'h700;
        bus.i_request = 1'b1;
        exp_grant_q.push_back(32'h700);
        wait_req(ok);
        compared++;
        if (!ok) begin mismatched++; $display("FAIL rstmid_req: got mem_request=0, want 1"); end
        #2;
        rst = 1'b0;
        #1;
        compared++;
        if ({bus.mem_request, bus.i_valid} !== 2'b00 || dbg_state !== IDLE) begin
            mismatched++;
            $display("FAIL rstmid_drop: got mem_request=%b i_valid=%b state=%0d, want 0/0/IDLE",
                     bus.mem_request, bus.i_valid, dbg_state);
        end
        bus.i_request = 1'b0;
        repeat (2) tick();
        rst = 1'b1;
        tick();
        bus.i_addr    = 32'h704;
        bus.i_request = 1'b1;
        exp_grant_q.push_back(32'h704);
        exp_i_q.push_back({1'b0, 32'h0000_0013});
        wait_req(ok);
        compared++;
        if (!ok) begin mismatched++; $display("FAIL rstmid_refetch_req: got mem_request=0, want 1"); end
        tick();
        bus.mem_valid = 1'b1;
        bus.mem_rdata = 32'h0000_0013;
        @(negedge clk);
        compared++;
        if ({bus.i_valid, bus.i_err, bus.i_rdata} !== {1'b1, 1'b0, 32'h13}) begin
            mismatched++;
            $display("FAIL rstmid_refetch: got i_valid=%b i_err=%b i_rdata=%h, want 1/0/13",
                     bus.i_valid, bus.i_err, bus.i_rdata);
        end
        tick();
        bus.mem_valid = 1'b0;
        bus.i_request = 1'b0;
        repeat (2) tick();
    endtask

    // Sequence of scenarios and final report
    initial begin
        rst           = 1'b0;
        bus.i_request = 1'b0;
        bus.i_addr    = '0;
        bus.d_request = 1'b0;
        bus.d_we_re   = 1'b0;
        bus.d_mask    = '0;
        bus.d_addr    = '0;
        bus.d_wdata   = '0;
        bus.mem_valid = 1'b0;
        bus.mem_rdata = '0;

        test_reset();
        test_fetch();
        test_store();
        test_contention();
        test_timeout();
        test_timeout_boundary();
        test_reset_mid();

        compared++;
        if (exp_grant_q.size() != 0) begin
            mismatched++;
            $display("FAIL grant_left: got %0d pending grants, want 0", exp_grant_q.size());
        end
        compared++;
        if (exp_i_q.size() != 0 || exp_d_q.size() != 0) begin
            mismatched++;
            $display("FAIL resp_left: got %0d i / %0d d pending, want 0/0", exp_i_q.size(), exp_d_q.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-to-one memory port arbiter placed between the RV32I core and a single shared instruction/data memory. It accepts the core's fetch request and load/store request and grants exactly one at a time to the unified memory port. It latches the winning transaction and routes the memory's valid/read data back to the owner. Two mechanisms keep the core from stalling forever: a bounded starvation guard for fetch and a response timeout.

## Interface
Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, data width
- MAX_DATA_STREAK, 4, consecutive data grants allowed while a fetch waits; must be ≥1
- TIMEOUT, 16, cycles in a busy state before abort; must be ≥2

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  reset, asynchronous, active-low
- i_request  in  1  fetch request, held until i_valid
- i_addr  in  ADDR_W  fetch address
- i_valid  out  1  fetch completion pulse
- i_rdata  out  DATA_W  instruction word, meaningful while i_valid
- i_err  out  1  fetch aborted by timeout, meaningful while i_valid
- d_request  in  1  load/store request, held until d_valid
- d_we_re  in  1  1 = store, 0 = load
- d_mask  in  4  byte enables
- d_addr  in  ADDR_W  data address
- d_wdata  in  DATA_W  store data
- d_valid, d_rdata, d_err  out  1/DATA_W/1  as fetch side
- mem_request  out  1  shared-port request
- mem_we_re  out  1  1 = write, 0 = read
- mem_mask  out  4  byte enables
- mem_addr  out  ADDR_W  address
- mem_wdata  out  DATA_W  write data
- mem_valid  in  1  memory completion, one cycle
- mem_rdata  in  DATA_W  read data, valid with mem_valid

## Operation
- FSM states: IDLE, IBUSY, DBUSY. Reset state is IDLE.
- IDLE, neither request: stay.
- IDLE, only d_request: go to DBUSY.
- IDLE, only i_request: go to IBUSY.
- IDLE, both requests: DBUSY, unless streak == MAX_DATA_STREAK, then IBUSY.
- At grant, latch the winner's addr, we_re, mask and wdata into mem_* registers. A fetch latches we_re=0, mask=4'hF, wdata=0.
- The streak counter increments on each data grant made while i_request is high. It clears on any fetch grant and on any data grant made while i_request is low. It saturates at MAX_DATA_STREAK.
- IBUSY/DBUSY hold mem_request=1 and all mem_* fields stable.
- Normal completion: mem_valid=1 in a busy state.
  - The owner's valid is driven combinationally that cycle, with rdata=mem_rdata and err=0.
  - The FSM goes to IDLE and mem_request drops.
- Timeout: a timer clears on grant and counts busy cycles.
  - If timer == TIMEOUT-1 and mem_valid=0: owner valid=1, err=1, rdata=0. FSM goes to IDLE.
  - If mem_valid arrives in that same cycle, it is a normal completion (no error).
- mem_valid in IDLE (late or spurious response) is ignored: no valid pulse.
- A request still high in the cycle after its valid is a new transaction.
- A requester dropping its request mid-transaction does not abort the transaction. The completion pulse is still produced.
- Non-owner valid/err are 0; non-owner rdata is 0.

## Timing
- Reset values:
  - All outputs 0.
  - mem_* registers 0.
  - State IDLE, streak 0, timer 0.
  - An asynchronous assertion mid-transaction drops mem_request immediately; no completion pulse is produced.
- Request sampled in IDLE at cycle N: mem_request=1 from cycle N+1.
- mem_valid at cycle M ≥ N+1: requester valid at M (combinational). mem_request=0 at M+1.
- Minimum transaction is 2 cycles, grant to completion. Back-to-back grants leave one IDLE cycle between transactions.
- Timeout abort occurs TIMEOUT cycles after mem_request rises.

## Structure
- Package mem_arb_pkg:
  - state enum
  - MEM_RD=1'b0, MEM_WR=1'b1
  - MASK_WORD=4'hF
- Sub-module mem_arb_timer: load/count/expire counter, width $clog2(TIMEOUT). Instanced once.
- Everything else sits in mem_arbiter: FSM, streak counter, latch registers, response routing.

## Test plan
- Fetch only: i_request, i_addr=0x100, memory responds 3 cycles later with 0x00500093 -> mem_addr=0x100, mem_we_re=0, mem_mask=F; i_valid for one cycle with i_rdata=0x00500093; d_valid=0.
- Store only: d_we_re=1, d_mask=4'b0011, d_addr=0x2004, d_wdata=0xBEEF -> mem_* match and stay stable until mem_valid; d_valid=1, d_err=0.
- Contention: both requests held continuously, MAX_DATA_STREAK=4 -> grant order D,D,D,D,I,D,D,D,D,I.
- Timeout: DBUSY, memory never responds, TIMEOUT=16 -> d_valid=1 and d_err=1 in the 16th busy cycle; later mem_valid in IDLE is ignored.
- Boundary: mem_valid in the same cycle as timer expiry -> d_err=0 and d_rdata=mem_rdata.
- Reset mid-transaction: rst low during IBUSY -> mem_request=0 at once; no i_valid; after release, a new fetch works normally.
